// File: rtl/palette_lut_rw.sv
// Writable multi-palette colour LUT: {pal_sel,index} -> 24-bit RGB through a 2-stage pipeline.
// After reset an init sequencer fills every entry with DEFAULT_RGB before writes and lookups are accepted.
module palette_lut_rw #(
  parameter int                   INDEX_W         = 4,
  parameter int                   PAL_SEL_W       = 2,
  parameter int                   COLOR_W         = 8,
  parameter int                   TRANSPARENT_IDX = 15,
  parameter logic [3*COLOR_W-1:0] DEFAULT_RGB     = 24'hFE06FF
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   pix_valid_in,
  input  logic [PAL_SEL_W-1:0]   pal_sel,
  input  logic [INDEX_W-1:0]     index,
  output logic                   pix_valid_out,
  output logic [COLOR_W-1:0]     red,
  output logic [COLOR_W-1:0]     green,
  output logic [COLOR_W-1:0]     blue,
  output logic                   transparent,
  input  logic                   wr_en,
  input  logic [PAL_SEL_W-1:0]   wr_pal,
  input  logic [INDEX_W-1:0]     wr_idx,
  input  logic [3*COLOR_W-1:0]   wr_rgb,
  output logic                   wr_ready,
  output logic                   init_busy,
  output logic                   dbg_state_o
);

  localparam int ADDR_W = PAL_SEL_W + INDEX_W;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int RGB_W  = 3 * COLOR_W;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;

  logic [RGB_W-1:0]  mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [RGB_W-1:0]  mem_wdata;

  logic              lk_req;
  logic              s1_valid_q;
  logic [ADDR_W-1:0] s1_addr_q;
  logic              s1_transp_q;

  logic              out_valid_q;
  logic [RGB_W-1:0]  out_rgb_q;
  logic              out_transp_q;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + ADDR_W'(1);
      if (&init_cnt_q) state_d = ST_RUN;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Write handshake: in RUN wr_ready=1 and every cycle with wr_en=1 is one accepted write;
  // in INIT wr_ready=0 and wr_en is dropped, the sequencer owns the write port.
  assign mem_we    = Reset_n && ((state_q == ST_INIT) || wr_en);
  assign mem_waddr = (state_q == ST_INIT) ? init_cnt_q : {wr_pal, wr_idx};
  assign mem_wdata = (state_q == ST_INIT) ? DEFAULT_RGB : wr_rgb;

  always_ff @(posedge Clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign lk_req = pix_valid_in && (state_q == ST_RUN);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      s1_transp_q <= 1'b0;
    end else begin
      s1_valid_q <= lk_req;
      if (lk_req) begin
        s1_addr_q   <= {pal_sel, index};
        s1_transp_q <= (index == INDEX_W'(TRANSPARENT_IDX));
      end
    end
  end

  // Reading mem here sees the pre-edge contents, so a same-edge write returns old data.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      out_valid_q  <= 1'b0;
      out_rgb_q    <= '0;
      out_transp_q <= 1'b0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_rgb_q    <= mem[s1_addr_q];
        out_transp_q <= s1_transp_q;
      end
    end
  end

  assign pix_valid_out = out_valid_q;
  assign red           = out_rgb_q[RGB_W-1 -: COLOR_W];
  assign green         = out_rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign blue          = out_rgb_q[COLOR_W-1:0];
  assign transparent   = out_transp_q;
  assign wr_ready      = (state_q == ST_RUN);
  assign init_busy     = (state_q == ST_INIT);
  assign dbg_state_o   = state_q[0];

endmodule

// File: tb/tb_palette_lut_rw.sv
// Bench for palette_lut_rw: palette contents held in a plain array model, lookup
// results predicted when a request is presented and checked two cycles later.
module tb_palette_lut_rw;

  localparam logic [23:0] DEF = 24'hFE06FF;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        pix_valid_in;
  logic [1:0]  pal_sel;
  logic [3:0]  index;
  logic        pix_valid_out;
  logic [7:0]  red, green, blue;
  logic        transparent;
  logic        wr_en;
  logic [1:0]  wr_pal;
  logic [3:0]  wr_idx;
  logic [23:0] wr_rgb;
  logic        wr_ready;
  logic        init_busy;
  logic        dbg_state_o;

  int errors = 0;
  int checks = 0;

  // model: palette contents and per-cycle expected output {valid, transparent, rgb}
  logic [23:0] ref_mem [64];
  logic [25:0] exp_q[$];
  bit          model_run = 1'b0;

  palette_lut_rw dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .pix_valid_in(pix_valid_in), .pal_sel(pal_sel), .index(index),
    .pix_valid_out(pix_valid_out), .red(red), .green(green), .blue(blue),
    .transparent(transparent),
    .wr_en(wr_en), .wr_pal(wr_pal), .wr_idx(wr_idx), .wr_rgb(wr_rgb),
    .wr_ready(wr_ready), .init_busy(init_busy), .dbg_state_o(dbg_state_o)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic fill_default();
    for (int a = 0; a < 64; a++) ref_mem[a] = DEF;
  endtask

  // Drives one cycle of inputs and records what the palette should return for it.
  task automatic drive(input bit lv, input logic [1:0] lp, input logic [3:0] li,
                       input bit we, input logic [1:0] wp, input logic [3:0] wi,
                       input logic [23:0] wd);
    @(negedge Clk);
    pix_valid_in = lv; pal_sel = lp; index = li;
    wr_en = we; wr_pal = wp; wr_idx = wi; wr_rgb = wd;
    if (we && model_run) ref_mem[{wp, wi}] = wd;
    if (lv && model_run) exp_q.push_back({1'b1, (li == 4'd15), ref_mem[{lp, li}]});
    else                 exp_q.push_back(26'd0);
  endtask

  task automatic test_reset();
    int cnt;
    fill_default();
    Reset_n = 1'b0; pix_valid_in = 1'b0; pal_sel = '0; index = '0;
    wr_en = 1'b0; wr_pal = '0; wr_idx = '0; wr_rgb = '0;
    repeat (3) @(negedge Clk);
    checks++;
    if (pix_valid_out !== 1'b0 || {red, green, blue} !== 24'h0 || transparent !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b rgb=%h tr=%b, want 0/000000/0",
               pix_valid_out, {red, green, blue}, transparent);
    end
    checks++;
    if (wr_ready !== 1'b0 || init_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_status: wr_ready=%b init_busy=%b, want 0/1", wr_ready, init_busy);
    end
    // lookups and writes requested during init must be ignored
    Reset_n = 1'b1; pix_valid_in = 1'b1; pal_sel = 2'd0; index = 4'd0;
    wr_en = 1'b1; wr_pal = 2'd0; wr_idx = 4'd0; wr_rgb = 24'h123456;
    cnt = 0;
    while (init_busy === 1'b1 && cnt < 200) begin
      checks++;
      if (wr_ready !== 1'b0 || pix_valid_out !== 1'b0) begin
        errors++;
        $display("FAIL init_quiet cycle %0d: wr_ready=%b valid=%b, want 0/0", cnt, wr_ready, pix_valid_out);
      end
      cnt++;
      @(negedge Clk);
    end
    pix_valid_in = 1'b0; wr_en = 1'b0;
    checks++;
    if (cnt != 64) begin
      errors++;
      $display("FAIL init_length: busy for %0d cycles, want 64", cnt);
    end
    checks++;
    if (wr_ready !== 1'b1 || init_busy !== 1'b0) begin
      errors++;
      $display("FAIL init_done: wr_ready=%b init_busy=%b, want 1/0", wr_ready, init_busy);
    end
    model_run = 1'b1;
    exp_q.push_back(26'd0);
  endtask

  task automatic test_default_lookup();
    logic [25:0] e;
    for (int c = 0; c < 5; c++) begin
      if (c == 0)      drive(1'b1, 2'd2, 4'd3, 1'b0, 2'd0, 4'd0, 24'h0);
      else if (c == 1) drive(1'b1, 2'd0, 4'd0, 1'b0, 2'd0, 4'd0, 24'h0);
      else             drive(1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'd0, 24'h0);
      if (exp_q.size() == 3) begin
        e = exp_q.pop_front();
        checks++;
        if (pix_valid_out !== e[25]) begin
          errors++;
          $display("FAIL default_lookup valid: got %b want %b", pix_valid_out, e[25]);
        end else if (e[25]) begin
          checks++;
          if ({red, green, blue} !== e[23:0] || transparent !== e[24]) begin
            errors++;
            $display("FAIL default_lookup data: got %h/%b want %h/%b",
                     {red, green, blue}, transparent, e[23:0], e[24]);
          end
        end
      end
    end
  endtask

  task automatic test_write_read();
    logic [25:0] e;
    for (int c = 0; c < 5; c++) begin
      if (c == 0)      drive(1'b0, 2'd0, 4'd0, 1'b1, 2'd1, 4'd5, 24'h00A500);
      else if (c == 1) drive(1'b1, 2'd1, 4'd5, 1'b0, 2'd0, 4'd0, 24'h0);
      else if (c == 2) drive(1'b1, 2'd0, 4'd5, 1'b0, 2'd0, 4'd0, 24'h0);
      else             drive(1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'd0, 24'h0);
      if (exp_q.size() == 3) begin
        e = exp_q.pop_front();
        checks++;
        if (pix_valid_out !== e[25]) begin
          errors++;
          $display("FAIL write_read valid: got %b want %b", pix_valid_out, e[25]);
        end else if (e[25]) begin
          checks++;
          if ({red, green, blue} !== e[23:0] || transparent !== e[24]) begin
            errors++;
            $display("FAIL write_read data: got %h/%b want %h/%b",
                     {red, green, blue}, transparent, e[23:0], e[24]);
          end
        end
      end
    end
  endtask

  task automatic test_collision();
    logic [25:0] e;
    for (int c = 0; c < 5; c++) begin
      if (c == 0)      drive(1'b1, 2'd0, 4'd0, 1'b0, 2'd0, 4'd0, 24'h0);
      else if (c == 1) drive(1'b1, 2'd0, 4'd0, 1'b1, 2'd0, 4'd0, 24'h112233);
      else if (c == 2) drive(1'b1, 2'd0, 4'd0, 1'b0, 2'd0, 4'd0, 24'h0);
      else             drive(1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'd0, 24'h0);
      if (exp_q.size() == 3) begin
        e = exp_q.pop_front();
        checks++;
        if (pix_valid_out !== e[25]) begin
          errors++;
          $display("FAIL collision valid: got %b want %b", pix_valid_out, e[25]);
        end else if (e[25]) begin
          checks++;
          if ({red, green, blue} !== e[23:0] || transparent !== e[24]) begin
            errors++;
            $display("FAIL collision data: got %h/%b want %h/%b",
                     {red, green, blue}, transparent, e[23:0], e[24]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [25:0] e;
    int          n_valid;
    n_valid = 0;
    for (int c = 0; c < 19; c++) begin
      if (c < 16) drive(1'b1, 2'd3, 4'(c), 1'b0, 2'd0, 4'd0, 24'h0);
      else        drive(1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'd0, 24'h0);
      if (exp_q.size() == 3) begin
        e = exp_q.pop_front();
        checks++;
        if (pix_valid_out !== e[25]) begin
          errors++;
          $display("FAIL back_to_back valid: got %b want %b", pix_valid_out, e[25]);
        end else if (e[25]) begin
          n_valid++;
          checks++;
          if ({red, green, blue} !== e[23:0] || transparent !== e[24]) begin
            errors++;
            $display("FAIL back_to_back data: got %h/%b want %h/%b",
                     {red, green, blue}, transparent, e[23:0], e[24]);
          end
        end
      end
    end
    checks++;
    if (n_valid != 16) begin
      errors++;
      $display("FAIL back_to_back count: got %0d valid outputs want 16", n_valid);
    end
    // outputs hold the last result (pal 3, idx 15) while invalid
    checks++;
    if (pix_valid_out !== 1'b0 || {red, green, blue} !== ref_mem[{2'd3, 4'd15}] || transparent !== 1'b1) begin
      errors++;
      $display("FAIL hold_last: valid=%b rgb=%h tr=%b want 0/%h/1",
               pix_valid_out, {red, green, blue}, transparent, ref_mem[{2'd3, 4'd15}]);
    end
  endtask

  task automatic test_random();
    logic [25:0] e;
    for (int c = 0; c < 302; c++) begin
      if (c < 300)
        drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
              24'($urandom));
      else
        drive(1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'd0, 24'h0);
      if (exp_q.size() == 3) begin
        e = exp_q.pop_front();
        checks++;
        if (pix_valid_out !== e[25]) begin
          errors++;
          $display("FAIL random valid cycle %0d: got %b want %b", c, pix_valid_out, e[25]);
        end else if (e[25]) begin
          checks++;
          if ({red, green, blue} !== e[23:0] || transparent !== e[24]) begin
            errors++;
            $display("FAIL random data cycle %0d: got %h/%b want %h/%b",
                     c, {red, green, blue}, transparent, e[23:0], e[24]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [25:0] e;
    logic [5:0]  aa;
    int          cnt;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'b1, 2'd2, 4'(c), 24'hA0B0C0 + 24'(c));
      if (exp_q.size() == 3) begin
        e = exp_q.pop_front();
        checks++;
        if (pix_valid_out !== e[25]) begin
          errors++;
          $display("FAIL reset_mid stream valid: got %b want %b", pix_valid_out, e[25]);
        end
      end
    end
    @(negedge Clk);
    Reset_n = 1'b0; wr_en = 1'b0;
    exp_q.delete();
    model_run = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    checks++;
    if (pix_valid_out !== 1'b0 || init_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid flush: valid=%b init_busy=%b want 0/1", pix_valid_out, init_busy);
    end
    cnt = 0;
    while (init_busy === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge Clk);
    end
    pix_valid_in = 1'b0;
    checks++;
    if (cnt != 64) begin
      errors++;
      $display("FAIL reset_mid init_length: busy for %0d cycles want 64", cnt);
    end
    fill_default();
    model_run = 1'b1;
    exp_q.push_back(26'd0);
    for (int a = 0; a < 66; a++) begin
      aa = 6'(a);
      if (a < 64) drive(1'b1, aa[5:4], aa[3:0], 1'b0, 2'd0, 4'd0, 24'h0);
      else        drive(1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'd0, 24'h0);
      if (exp_q.size() == 3) begin
        e = exp_q.pop_front();
        checks++;
        if (pix_valid_out !== e[25]) begin
          errors++;
          $display("FAIL reset_mid readback valid: got %b want %b", pix_valid_out, e[25]);
        end else if (e[25]) begin
          checks++;
          if ({red, green, blue} !== e[23:0] || transparent !== e[24]) begin
            errors++;
            $display("FAIL reset_mid readback data: got %h/%b want %h/%b",
                     {red, green, blue}, transparent, e[23:0], e[24]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_lookup();
    test_write_read();
    test_collision();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/palette_lut_rw.md
Name: palette_lut_rw

Overview:
- Writable, multi-palette colour lookup table for the sprite/background renderers. It replaces fixed per-sprite combinational palettes.
- Maps a pixel index plus a palette select to 24-bit RGB through a 2-stage registered pipeline, and flags transparent pixels.
- Palette contents are loaded at runtime through a write port. A hardware init sequencer fills every entry with a default colour after reset.
- Sits between the sprite ROM readout and the VGA colour mux.

Parameters:
- INDEX_W, 4, bits of colour index per palette (2^INDEX_W entries per palette)
- PAL_SEL_W, 2, bits of palette select (2^PAL_SEL_W palettes)
- COLOR_W, 8, bits per colour channel
- TRANSPARENT_IDX, 15, index value reported as transparent in every palette
- DEFAULT_RGB, 24'hFE06FF, fill value written by the init sequencer ({R,G,B}, 3*COLOR_W bits)

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  synchronous active-low reset
- pix_valid_in  in  1  lookup request valid
- pal_sel  in  PAL_SEL_W  palette for this lookup
- index  in  INDEX_W  colour index for this lookup
- pix_valid_out  out  1  lookup result valid
- red  out  COLOR_W  looked-up red
- green  out  COLOR_W  looked-up green
- blue  out  COLOR_W  looked-up blue
- transparent  out  1  result index equalled TRANSPARENT_IDX
- wr_en  in  1  palette write strobe
- wr_pal  in  PAL_SEL_W  palette to write
- wr_idx  in  INDEX_W  entry to write
- wr_rgb  in  3*COLOR_W  {R,G,B} data to write
- wr_ready  out  1  write accepted this cycle when wr_en=1
- init_busy  out  1  init sequencer running

Behaviour:
- Clock and reset: one clock, Clk. Reset_n is synchronous and active-low, sampled on the rising edge of Clk.
- Storage: DEPTH = 2^(PAL_SEL_W+INDEX_W) words of 3*COLOR_W bits. Address = {pal_sel, index}. Single write port, single read port.
- Reset values (while Reset_n=0):
  - pix_valid_out=0, red=green=blue=0, transparent=0.
  - wr_ready=0, init_busy=1.
  - Init counter=0; both pipeline stages invalid.
- States: INIT, RUN.
  - Reset forces INIT with counter=0.
- INIT:
  - Each cycle after Reset_n=1, writes DEFAULT_RGB to address counter, then increments the counter.
  - After writing address DEPTH-1, moves to RUN on the next edge. INIT therefore lasts exactly DEPTH cycles after reset release.
  - init_busy=1 and wr_ready=0 throughout INIT. wr_en is ignored.
  - pix_valid_in is ignored: no lookup enters the pipeline and pix_valid_out stays 0.
- RUN:
  - init_busy=0 and wr_ready=1.
  - A write occurs at any edge where wr_en=1. Write accepted in cycle N is readable by a lookup presented in cycle N+1 or later.
- Lookup pipeline, latency 2:
  - Edge 1: registers valid, address, and transparency compare (index==TRANSPARENT_IDX).
  - Edge 2: registers the memory read data and transparency into the outputs, and sets pix_valid_out.
  - Request presented in cycle N yields pix_valid_out=1 in cycle N+2.
  - Throughput: one lookup per cycle, no stalls, no backpressure.
- Read/write collision: if the stage-1 address equals the address written at the same edge, the result carries the OLD data. The next lookup to that address returns the new data.
- When pix_valid_out=0, red/green/blue/transparent hold their last values. Consumers must qualify them with pix_valid_out.
- transparent is independent of pal_sel. RGB is still looked up for transparent indices.
- Reset mid-operation:
  - Flushes both pipeline stages; in-flight results are discarded, with pix_valid_out=0 the cycle after reset is sampled.
  - Restarts INIT from address 0. Any palette contents are overwritten with DEFAULT_RGB.
- Simultaneous write and lookup to different addresses: both complete with no interaction.

Test Plan:
- Reset, then hold Reset_n=1 for DEPTH=64 cycles with defaults -> init_busy=1 for exactly 64 cycles, then 0. wr_ready rises in the same cycle init_busy falls.
- After init, look up pal_sel=2, index=3 -> two cycles later pix_valid_out=1, {red,green,blue}=FE,06,FF, transparent=0.
- Write pal 1, idx 5 = 24'h00A500; next cycle look up pal 1, idx 5 -> result 00,A5,00 at cycle +2. Pal 0, idx 5 is still FE06FF.
- Issue a write to pal 0, idx 0 = 24'h112233 on the same edge the stage-1 register holds that address -> that lookup returns FE06FF; an immediately following lookup returns 11,22,33.
- Back-to-back lookups on 16 consecutive cycles of index 0..15 in pal 3 -> 16 consecutive valid outputs in order. transparent=1 only for index 15.
- Assert Reset_n=0 for 1 cycle during streaming lookups, after prior writes -> pix_valid_out=0 next cycle and init_busy=1. All entries read FE06FF after the 64-cycle init.
